// File: rtl/hazard_forward_unit_if.sv
// rtl/hazard_forward_unit_if.sv - pipeline-side signal bundle for the hazard/forwarding unit
interface hazard_forward_if #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC*ADDR_W-1:0] id_src;
  logic [NUM_SRC*ADDR_W-1:0] ex_src;
  logic [ADDR_W-1:0]         idex_rd;
  logic                      idex_reg_write;
  logic                      idex_mem_read;
  logic [ADDR_W-1:0]         exmem_rd;
  logic                      exmem_reg_write;
  logic [ADDR_W-1:0]         memwb_rd;
  logic                      memwb_reg_write;
  logic                      flush;
  logic                      clear_stats;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic [NUM_SRC-1:0]        id_bypass;
  logic                      stall;
  logic                      bubble;
  logic [15:0]               stall_cycles;

  modport master (
    output id_src, ex_src, idex_rd, idex_reg_write, idex_mem_read,
           exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write,
           flush, clear_stats,
    input  fwd_sel, id_bypass, stall, bubble, stall_cycles
  );

  modport slave (
    input  id_src, ex_src, idex_rd, idex_reg_write, idex_mem_read,
           exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write,
           flush, clear_stats,
    output fwd_sel, id_bypass, stall, bubble, stall_cycles
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - operand forwarding, WB bypass and load-use stall control
module hazard_forward_unit #(
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  hazard_forward_if.slave  bus
);
  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [2:0] HOLD_INIT = 3'(LOAD_LAT - 1);

  state_t            state;
  logic [2:0]        cnt;
  logic [15:0]       stats;
  logic              hz;
  logic              stall_int;
  logic [ADDR_W-1:0] src_ex;
  logic [ADDR_W-1:0] src_id;

  // EX/MEM is checked first so the newest producer always wins
  always_comb begin
    bus.fwd_sel   = '0;
    bus.id_bypass = '0;
    hz            = 1'b0;
    src_ex        = '0;
    src_id        = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ex = bus.ex_src[i*ADDR_W +: ADDR_W];
      src_id = bus.id_src[i*ADDR_W +: ADDR_W];
      if (bus.exmem_reg_write && (bus.exmem_rd != '0) && (bus.exmem_rd == src_ex))
        bus.fwd_sel[2*i +: 2] = 2'b10;
      else if (bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == src_ex))
        bus.fwd_sel[2*i +: 2] = 2'b01;
      bus.id_bypass[i] = bus.memwb_reg_write && (bus.memwb_rd != '0) && (bus.memwb_rd == src_id);
      if (bus.idex_mem_read && bus.idex_reg_write && (bus.idex_rd != '0) && (bus.idex_rd == src_id))
        hz = 1'b1;
    end
  end

  // Reset and flush both suppress the stall in the very cycle they are seen
  assign stall_int        = !reset && !bus.flush && ((state == HOLD) || hz);
  assign bus.stall        = stall_int;
  assign bus.bubble       = stall_int;
  assign bus.stall_cycles = stats;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      stats <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.flush && hz && (LOAD_LAT > 1)) begin
            state <= HOLD;
            cnt   <= HOLD_INIT;
          end
        end
        HOLD: begin
          if (bus.flush || (cnt <= 3'd1)) begin
            state <= IDLE;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 3'd0;
        end
      endcase
      if (bus.clear_stats)
        stats <= 16'd0;
      else if (stall_int && (stats != 16'hFFFF))
        stats <= stats + 16'd1;
    end
  end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed checks of forwarding, bypass, stall FSM and stats
module tb_hazard_forward_unit;
  logic       clk;
  logic       reset;
  logic [9:0] id_src, ex_src;
  logic [4:0] idex_rd, exmem_rd, memwb_rd;
  logic       idex_reg_write, idex_mem_read, exmem_reg_write, memwb_reg_write;
  logic       flush, clear_stats;
  int         tests_run = 0;
  int         failed = 0;

  hazard_forward_if #(.ADDR_W(5), .NUM_SRC(2)) h1 ();
  hazard_forward_if #(.ADDR_W(5), .NUM_SRC(2)) h3 ();
  hazard_forward_if #(.ADDR_W(5), .NUM_SRC(2)) h4 ();

  always_comb begin
    h1.id_src = id_src; h1.ex_src = ex_src; h1.idex_rd = idex_rd;
    h1.idex_reg_write = idex_reg_write; h1.idex_mem_read = idex_mem_read;
    h1.exmem_rd = exmem_rd; h1.exmem_reg_write = exmem_reg_write;
    h1.memwb_rd = memwb_rd; h1.memwb_reg_write = memwb_reg_write;
    h1.flush = flush; h1.clear_stats = clear_stats;
    h3.id_src = id_src; h3.ex_src = ex_src; h3.idex_rd = idex_rd;
    h3.idex_reg_write = idex_reg_write; h3.idex_mem_read = idex_mem_read;
    h3.exmem_rd = exmem_rd; h3.exmem_reg_write = exmem_reg_write;
    h3.memwb_rd = memwb_rd; h3.memwb_reg_write = memwb_reg_write;
    h3.flush = flush; h3.clear_stats = clear_stats;
    h4.id_src = id_src; h4.ex_src = ex_src; h4.idex_rd = idex_rd;
    h4.idex_reg_write = idex_reg_write; h4.idex_mem_read = idex_mem_read;
    h4.exmem_rd = exmem_rd; h4.exmem_reg_write = exmem_reg_write;
    h4.memwb_rd = memwb_rd; h4.memwb_reg_write = memwb_reg_write;
    h4.flush = flush; h4.clear_stats = clear_stats;
  end

  hazard_forward_unit #(.ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(h1.slave));
  hazard_forward_unit #(.ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(h3.slave));
  hazard_forward_unit #(.ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(4)) dut4 (.clk(clk), .reset(reset), .bus(h4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_src = '0; ex_src = '0; idex_rd = '0; exmem_rd = '0; memwb_rd = '0;
    idex_reg_write = 0; idex_mem_read = 0; exmem_reg_write = 0; memwb_reg_write = 0;
    flush = 0;
  endtask

  // Load in EX writing r8, ID operand 1 reads r8
  task automatic hz_on();
    idex_mem_read = 1; idex_reg_write = 1; idex_rd = 5'd8; id_src = {5'd8, 5'd0};
  endtask

  initial begin
    clear_inputs();
    clear_stats = 0;
    reset = 1;
    @(negedge clk);
    hz_on(); ex_src = {5'd0, 5'd5}; exmem_rd = 5'd5; exmem_reg_write = 1;
    #1;
    check("rst_stall", 16'(h1.stall), 16'd0);
    check("rst_bubble", 16'(h4.bubble), 16'd0);
    check("rst_fwd", 16'(h1.fwd_sel), 16'b0010);
    @(negedge clk); #1;
    check("rst_stats", h1.stall_cycles, 16'd0);
    check("rst_stall3", 16'(h3.stall), 16'd0);

    @(negedge clk);
    reset = 0; clear_inputs();
    exmem_rd = 5'd5; memwb_rd = 5'd5; exmem_reg_write = 1; memwb_reg_write = 1;
    ex_src = {5'd3, 5'd5};
    #1 check("prio_exmem", 16'(h1.fwd_sel), 16'b0010);
    exmem_reg_write = 0;
    #1 check("prio_memwb", 16'(h1.fwd_sel), 16'b0001);

    @(negedge clk);
    clear_inputs();
    idex_reg_write = 1; idex_mem_read = 1; exmem_reg_write = 1; memwb_reg_write = 1;
    #1;
    check("r0_fwd", 16'(h1.fwd_sel), 16'd0);
    check("r0_bypass", 16'(h1.id_bypass), 16'd0);
    check("r0_stall", 16'(h3.stall), 16'd0);

    @(negedge clk);
    clear_inputs();
    memwb_rd = 5'd12; memwb_reg_write = 1; id_src = {5'd0, 5'd12}; ex_src = {5'd12, 5'd0};
    #1;
    check("wb_bypass", 16'(h1.id_bypass), 16'b01);
    check("wb_fwd_op1", 16'(h1.fwd_sel), 16'b0100);
    @(negedge clk); clear_inputs();
    @(negedge clk); #1;
    check("no_stall_stats", h1.stall_cycles, 16'd0);

    // One load-use hazard seen by LOAD_LAT 1, 3 and 4 units at once
    @(negedge clk); hz_on(); #1;
    check("lu_stall1", 16'(h1.stall), 16'd1);
    check("lu_bubble1", 16'(h1.bubble), 16'd1);
    check("lu3_c1", 16'(h3.stall), 16'd1);
    @(negedge clk); clear_inputs(); #1;
    check("lu1_done", 16'(h1.stall), 16'd0);
    check("lu1_stats", h1.stall_cycles, 16'd1);
    check("lu3_c2", 16'(h3.stall), 16'd1);
    @(negedge clk); #1;
    check("lu3_c3", 16'(h3.stall), 16'd1);
    @(negedge clk); #1;
    check("lu3_done", 16'(h3.stall), 16'd0);
    check("lu3_stats", h3.stall_cycles, 16'd3);
    check("lu1_stats_hold", h1.stall_cycles, 16'd1);
    repeat (4) @(negedge clk);

    clear_stats = 1;
    @(negedge clk); clear_stats = 0; #1;
    check("clr_stats3", h3.stall_cycles, 16'd0);

    @(negedge clk); hz_on(); #1;
    check("fl_c1", 16'(h3.stall), 16'd1);
    @(negedge clk); clear_inputs(); flush = 1; #1;
    check("fl_c2_stall", 16'(h3.stall), 16'd0);
    check("fl_c2_bubble", 16'(h3.bubble), 16'd0);
    @(negedge clk); flush = 0; #1;
    check("fl_c3_stall", 16'(h3.stall), 16'd0);
    check("fl_stats", h3.stall_cycles, 16'd1);

    @(negedge clk); hz_on(); flush = 1; #1;
    check("flhz_stall", 16'(h1.stall), 16'd0);
    @(negedge clk); clear_inputs(); #1;
    check("flhz_stats", h1.stall_cycles, 16'd1);
    check("flhz_no_hold", 16'(h3.stall), 16'd0);

    @(negedge clk); clear_stats = 1;
    @(negedge clk); clear_stats = 0; hz_on();
    repeat (65540) @(negedge clk);
    #1 check("sat_stats", h1.stall_cycles, 16'hFFFF);
    clear_stats = 1;
    #1 check("sat_clr_stall", 16'(h1.stall), 16'd1);
    @(negedge clk); clear_stats = 0; clear_inputs(); #1;
    check("sat_clr_stats", h1.stall_cycles, 16'd0);
    repeat (5) @(negedge clk);

    @(negedge clk); hz_on(); #1;
    check("rh_c1", 16'(h4.stall), 16'd1);
    @(negedge clk); clear_inputs(); reset = 1; #1;
    check("rh_c2_stall", 16'(h4.stall), 16'd0);
    @(negedge clk); reset = 0; #1;
    check("rh_c3_stall", 16'(h4.stall), 16'd0);
    check("rh_stats", h4.stall_cycles, 16'd0);
    @(negedge clk); #1;
    check("rh_c4_stall", 16'(h4.stall), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
